// File: rtl/booth_pkg.sv
// Shared types, default widths and saturation limits for the Booth product
// accumulator slice.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned LEN_W_DEF  = 4;

  // Largest and smallest values of a signed acc_w-bit accumulator.
  function automatic longint sat_max(input int unsigned acc_w);
    return (longint'(1) <<< (acc_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Control, product-in and result-out signals of the Booth product accumulator.
interface booth_product_accumulator_if
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);

  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_p;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_ovf;
  logic                     busy;

  modport master (
    output start, len, in_valid, in_p, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_p, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );

endinterface

// File: rtl/booth_sat_adder.sv
// Combinational signed add of a product into the accumulator, clamped to the
// accumulator range with an overflow indication.
module booth_sat_adder
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] p,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(ACC_W));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(ACC_W));

  logic signed [SUM_W-1:0] wide_c;

  // One extra bit makes any single-step excursion visible before clamping.
  always_comb begin
    wide_c = SUM_W'(acc) + SUM_W'(p);
    sum    = ACC_W'(wide_c);
    ovf    = 1'b0;
    if (wide_c > MAX_V) begin
      sum = ACC_W'(MAX_V);
      ovf = 1'b1;
    end else if (wide_c < MIN_V) begin
      sum = ACC_W'(MIN_V);
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates a programmed number of signed Booth products into a saturating
// accumulator and hands the sum to writeback over a valid/ready port.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input logic                        clk,
  input logic                        rst,
  booth_product_accumulator_if.slave bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;

  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    beat_c;

  booth_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .acc (acc_q),
    .p   (bus.in_p),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign beat_c = bus.in_valid && (state_q == ACCUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (beat_c) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state flop only; no input-to-output paths.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_acc   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule
